frame_scorer: RTL
=================

FRAME_SCORER -- requirements
Module: frame_scorer

Interface
REQ-001 Parameter: ROW, 19, bits per column word.
REQ-002 Parameter: WIDTH, 128, columns per frame.
REQ-003 Parameter: LOG_WIDTH, 7, column-index width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 en  input  1  the same read-enable driven to the upstream column memory.
REQ-008 data_in  input  ROW  column word from the memory read port, 1-cycle behind en.
REQ-009 busy  output  1  a frame is being scored.
REQ-010 result_valid  output  1  one-cycle pulse; results below are updated.
REQ-011 best_col  output  LOG_WIDTH  index of the highest-popcount column.
REQ-012 best_cnt  output  5  popcount of best_col (0..19).
REQ-013 total  output  12  total ones in frame, saturating at 4095.

Function
REQ-014 Register en_d <= en every cycle; the cycle with en_d=1 SHALL be a column cycle, and data_in then SHALL be treated as column col_idx.
REQ-015 First column cycle (en_d=1, busy=0): set busy=1, col_idx=0, and load accumulators from this column (not added to old values).
REQ-016 Each later column cycle: col_idx increments modulo 2^LOG_WIDTH, so it wraps 127->0 like the memory read pointer.
REQ-017 Per column: pc = popcount(data_in); total += pc, saturating at 4095.
REQ-018 Argmax: update best_cnt/best_col only when pc > best_cnt (strict); ties keep the earliest column in time.
REQ-019 End of frame (en_d=0, busy=1): at the next edge, result_valid=1 for exactly one cycle, best_col/best_cnt/total present the final values, and busy=0.
REQ-020 Latency: result_valid SHALL assert 2 cycles after the first cycle in which en is low.
REQ-021 Outputs SHALL hold their last result until the next result_valid; intermediate accumulation SHALL use internal registers only.
REQ-022 All-zero frame: best_col=0, best_cnt=0, total=0.
REQ-023 Back-to-back frames with a 1-cycle en gap: the result of frame N and the first column of frame N+1 SHALL both be handled correctly, with no carry-over.
REQ-024 A single-cycle en burst SHALL be a valid 1-column frame.
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-026 On rstn low: en_d, busy, result_valid, best_col, best_cnt, total, col_idx and the accumulators SHALL all be 0, asynchronously.
REQ-027 A frame in progress during reset SHALL be abandoned with no result_valid; scoring SHALL resume at the first en_d=1 after rstn is released.

Structure
REQ-028 ROW/WIDTH/LOG_WIDTH defaults, derived CNT_W=5 and TOT_W=12 SHALL live in the shared project definitions header used by the memory stage.
REQ-029 Popcount SHALL be one combinational sub-module, row_popcount (ROW-bit in, CNT_W-bit out).

Verification
REQ-030 Reset: assert rstn=0 mid-idle -> all outputs 0; release -> outputs stay 0 with en=0.
REQ-031 Frame of 128 columns, column 5 = 19'h7FFFF, all others one bit set -> best_col=5, best_cnt=19, total=146, result_valid pulse 2 cycles after en falls, busy low thereafter.
REQ-032 Tie: columns 3 and 10 popcount 7, the rest 0 -> best_col=3, best_cnt=7, total=14.
REQ-033 Two 128-column frames with a 1-cycle gap; frame A best col 20 (cnt 9), frame B all-zero -> first result (20,9,...), second result (0,0,0); no leakage.
REQ-034 Reset mid-frame at column 40 -> no result_valid; the following clean frame with column 100 = 4 ones -> best_col=100, best_cnt=4, total=4.
REQ-035 Wrap: en high for 130 columns, column 129 the only nonzero (3 ones) -> best_col=1, best_cnt=3, total=3.

Source files
------------

// File: rtl/frame_scorer_pkg.sv
// Shared frame geometry and derived widths for the column memory and scoring stages.
package frame_scorer_pkg;

    localparam int ROW       = 19;
    localparam int WIDTH     = 128;
    localparam int LOG_WIDTH = 7;
    localparam int CNT_W     = 5;
    localparam int TOT_W     = 12;

    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SCORE = 1'b1
    } score_state_t;

endpackage

// File: rtl/frame_scorer_popcount.sv
// Purely combinational count of set bits in one column word.
module row_popcount
    import frame_scorer_pkg::*;
#(
    parameter int ROW_W     = ROW,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic [ROW_W-1:0]     row,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < ROW_W; i++) begin
            cnt = cnt + CNT_WIDTH'(row[i]);
        end
    end

endmodule

// File: rtl/frame_scorer.sv
// Scores a frame of column words streamed from memory: argmax popcount column and total ones.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no frame open; next en_d=1 loads column 0 fresh
//   ST_SCORE | accumulating columns; en_d=0 publishes results and closes
module frame_scorer
    import frame_scorer_pkg::*;
#(
    parameter int ROW       = frame_scorer_pkg::ROW,
    parameter int WIDTH     = frame_scorer_pkg::WIDTH,
    parameter int LOG_WIDTH = frame_scorer_pkg::LOG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [ROW-1:0]       data_in,
    output logic                 busy,
    output logic                 result_valid,
    output logic [LOG_WIDTH-1:0] best_col,
    output logic [CNT_W-1:0]     best_cnt,
    output logic [TOT_W-1:0]     total
);

    localparam int SUM_W = TOT_W + 1;

    score_state_t         state_q, state_n;
    logic                 en_d;
    logic                 load, accum, finish;
    logic [CNT_W-1:0]     pc;
    logic [LOG_WIDTH-1:0] col_idx, col_nxt;
    logic [LOG_WIDTH-1:0] acc_col;
    logic [CNT_W-1:0]     acc_cnt;
    logic [TOT_W-1:0]     acc_total;
    logic [SUM_W-1:0]     sum;

    row_popcount #(
        .ROW_W     (ROW),
        .CNT_WIDTH (CNT_W)
    ) u_popcount (
        .row (data_in),
        .cnt (pc)
    );

    // Column index follows the memory read pointer, wrapping after the last column.
    assign col_nxt = (int'(col_idx) == WIDTH - 1) ? '0 : col_idx + 1'b1;
    assign sum     = {1'b0, acc_total} + SUM_W'(pc);
    assign busy    = (state_q == ST_SCORE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        load    = 1'b0;
        accum   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_d) begin
                    load    = 1'b1;
                    state_n = ST_SCORE;
                end
            end
            ST_SCORE: begin
                if (en_d) begin
                    accum = 1'b1;
                end else begin
                    finish  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_d         <= 1'b0;
            result_valid <= 1'b0;
            col_idx      <= '0;
            acc_col      <= '0;
            acc_cnt      <= '0;
            acc_total    <= '0;
            best_col     <= '0;
            best_cnt     <= '0;
            total        <= '0;
        end else begin
            en_d         <= en;
            result_valid <= finish;

            if (load) begin
                col_idx   <= '0;
                acc_col   <= '0;
                acc_cnt   <= pc;
                acc_total <= TOT_W'(pc);
            end else if (accum) begin
                col_idx   <= col_nxt;
                acc_total <= sum[TOT_W] ? TOT_MAX : sum[TOT_W-1:0];
                // Strict compare keeps the earliest column on ties.
                if (pc > acc_cnt) begin
                    acc_cnt <= pc;
                    acc_col <= col_nxt;
                end
            end

            if (finish) begin
                best_col <= acc_col;
                best_cnt <= acc_cnt;
                total    <= acc_total;
            end
        end
    end

endmodule
